// File: rtl/dct_transpose_buf_if.sv
// rtl/dct_transpose_buf_if.sv - column-in / row-out handshake bundle for the DCT transpose buffer
interface dct_transpose_buf_if #(
  parameter int SIZE = 10,
  parameter int N    = 8
);
  logic                     clear;
  logic                     in_valid;
  logic [N-1:0][SIZE-1:0]   in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [N-1:0][SIZE-1:0]   out_data;
  logic                     out_ready;
  logic                     out_last;
  logic                     overrun;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, overrun
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, overrun
  );
endinterface

// File: rtl/dct_transpose_buf.sv
// rtl/dct_transpose_buf.sv - ping-pong 8x8 transpose memory between column and row DCT stages
module dct_transpose_buf #(
  parameter int SIZE = 10,
  parameter int N    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dct_transpose_buf_if.slave bus
);
  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [SIZE-1:0] mem [2][N][N];  // [bank][row][col]
  logic [1:0]      full;
  logic            wbank;
  logic            rbank;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   rcnt;
  logic            overrun_q;
  logic            wr_fire;
  logic            rd_fire;

  assign bus.in_ready  = !full[wbank];
  assign bus.out_valid = full[rbank];
  assign bus.out_last  = full[rbank] && (rcnt == LAST);
  assign bus.overrun   = overrun_q;
  assign wr_fire       = bus.in_valid && bus.in_ready;
  assign rd_fire       = bus.out_valid && bus.out_ready;

  always_comb begin
    bus.out_data = '0;
    if (full[rbank]) begin
      for (int c = 0; c < N; c++) begin
        bus.out_data[c] = mem[rbank][rcnt][c];
      end
    end
  end

  // Storage has no reset; only the flags decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_fire && !bus.clear) begin
      for (int i = 0; i < N; i++) begin
        mem[wbank][i][wcnt] <= bus.in_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      overrun_q <= 1'b0;
    end else if (bus.clear) begin
      full      <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.in_valid && !bus.in_ready) begin
        overrun_q <= 1'b1;
      end
      if (wr_fire) begin
        if (wcnt == LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= !wbank;
          wcnt        <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      // A write can only finish on a non-full bank and a read only on a full one,
      // so the two flag updates never target the same bank.
      if (rd_fire) begin
        if (rcnt == LAST) begin
          full[rbank] <= 1'b0;
          rbank       <= !rbank;
          rcnt        <= '0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb/tb_dct_transpose_buf.sv - randomized self-checking bench for dct_transpose_buf
module tb_dct_transpose_buf;
  localparam int SIZE = 10;
  localparam int N    = 8;
  typedef logic [N-1:0][SIZE-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dct_transpose_buf_if #(.SIZE(SIZE), .N(N)) bus ();
  dct_transpose_buf #(.SIZE(SIZE), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   nt = 0;
  int   nf = 0;
  vec_t rows[$];  // rows still owed downstream, oldest first
  vec_t cols[N];  // columns of the block being assembled
  int   pcnt = 0;
  logic ovr = 1'b0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nt++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    rows.delete();
    pcnt = 0;
    ovr  = 1'b0;
  endtask

  function automatic int blocks();
    return (rows.size() + N - 1) / N;
  endfunction

  task automatic push_block();
    vec_t v;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) v[c] = cols[c][r];
      rows.push_back(v);
    end
  endtask

  task automatic check_outputs(input string tag);
    int   sz;
    vec_t e;
    sz = rows.size();
    e  = '0;
    if (sz > 0) e = rows[0];
    chk({tag, ".in_ready"},  80'(bus.in_ready),  80'(blocks() < 2));
    chk({tag, ".out_valid"}, 80'(bus.out_valid), 80'(sz > 0));
    chk({tag, ".out_last"},  80'(bus.out_last),  80'(sz % N == 1));
    chk({tag, ".out_data"},  80'(bus.out_data),  80'(e));
    chk({tag, ".overrun"},   80'(bus.overrun),   80'(ovr));
  endtask

  task automatic cyc(input string tag, output logic acc);
    logic rd;
    logic ov;
    vec_t d;
    check_outputs(tag);
    acc = bus.in_valid && (blocks() < 2);
    ov  = bus.in_valid && !(blocks() < 2);
    rd  = (rows.size() > 0) && bus.out_ready;
    d   = bus.in_data;
    @(posedge clk);
    #1;
    if (bus.clear) begin
      model_flush();
    end else begin
      if (ov) ovr = 1'b1;
      if (rd) void'(rows.pop_front());
      if (acc) begin
        cols[pcnt] = d;
        pcnt++;
        if (pcnt == N) begin
          push_block();
          pcnt = 0;
        end
      end
    end
  endtask

  task automatic send_col(input string tag, input vec_t d);
    logic acc;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      cyc(tag, acc);
      n++;
    end
    chk({tag, ".accept_timeout"}, 80'(acc), 80'(1));
  endtask

  task automatic drain(input string tag);
    logic acc;
    int   n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (rows.size() > 0 && n < 200) begin
      cyc(tag, acc);
      n++;
    end
    chk({tag, ".drained_valid"}, 80'(bus.out_valid), 80'(0));
  endtask

  function automatic vec_t pattern(input int base);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = SIZE'(base + i);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = SIZE'($urandom);
    return v;
  endfunction

  initial begin
    logic acc;
    vec_t v;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #1;
    model_flush();
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single block, row r element c must be 8c+r
    for (int k = 0; k < N; k++) send_col("single", pattern(8 * k));
    bus.in_valid = 1'b0;
    chk("single.row0_valid", 80'(bus.out_valid), 80'(1));
    chk("single.row0_c1", 80'(bus.out_data[1]), 80'(8));
    drain("single");

    for (int b = 0; b < 3; b++)
      for (int k = 0; k < N; k++) send_col("b2b", pattern(100 * b + 8 * k));
    drain("b2b");

    // both banks fill, then an overrun attempt, then release
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2 * N; k++) send_col("bp", pattern(4 * k));
    bus.in_valid = 1'b0;
    cyc("bp_hold", acc);
    chk("bp.in_ready_low", 80'(bus.in_ready), 80'(0));
    chk("bp.overrun_clean", 80'(bus.overrun), 80'(0));
    bus.in_valid = 1'b1;
    bus.in_data  = pattern(200);
    cyc("bp_stall", acc);
    chk("bp.overrun_set", 80'(bus.overrun), 80'(1));
    bus.out_ready = 1'b1;
    send_col("bp_17", pattern(200));
    drain("bp_drain");
    bus.clear = 1'b1;
    cyc("bp_clear", acc);
    bus.clear = 1'b0;
    chk("bp.overrun_cleared", 80'(bus.overrun), 80'(0));

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) v[i] = (k == 0) ? 10'h200 : (k == N - 1) ? 10'h1FF : 10'h000;
      send_col("signed", v);
    end
    bus.in_valid = 1'b0;
    chk("signed.c0", 80'(bus.out_data[0]), 80'(10'h200));
    chk("signed.c7", 80'(bus.out_data[7]), 80'(10'h1FF));
    drain("signed");

    for (int k = 0; k < 5; k++) send_col("pre_rst", rand_vec());
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_flush();
    check_outputs("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < N; k++) send_col("post_rst", pattern(8 * k + 1));
    drain("post_rst");

    // clear while row 3 is presented
    bus.out_ready = 1'b0;
    for (int k = 0; k < N; k++) send_col("clr_fill", rand_vec());
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cyc("clr_read", acc);
    chk("clr.row3_present", 80'(bus.out_valid && !bus.out_last), 80'(1));
    bus.clear = 1'b1;
    cyc("clr_pulse", acc);
    bus.clear = 1'b0;
    chk("clr.out_valid", 80'(bus.out_valid), 80'(0));
    chk("clr.in_ready", 80'(bus.in_ready), 80'(1));
    for (int k = 0; k < N; k++) send_col("clr_fresh", rand_vec());
    drain("clr_fresh");

    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = rand_vec();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cyc("rand", acc);
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
- Transpose memory between the column DCT stage and the row DCT stage of the 2-D DCT.
- Accepts eight 8-element column-result vectors per 8x8 block and emits eight 8-element row vectors of the same block.
- Ping-pong (two-bank) storage, so one block can be written while the previous block is read.
- Valid/ready handshake on both sides.

Parameters:
- SIZE, 10, signed element width; equals the column stage output width (its SIZE+2).
- N, 8, vector length and block dimension; fixed at 8, other values unsupported.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all block state.
- in_valid  input  1  in_data holds a column vector.
- in_data  input  SIZE x [N-1:0] signed  column vector; element i = row i of current column.
- in_ready  output  1  a write bank can accept a vector.
- out_valid  output  1  out_data holds a row vector.
- out_data  output  SIZE x [N-1:0] signed  row vector; element c = column c of current row.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  out_data is row 7 of a block.
- overrun  output  1  sticky flag: in_valid seen while in_ready=0.

Behaviour:
- Storage and pointers
  - Two banks, each N x N x SIZE registers.
  - Per-bank full flag; wbank and rbank pointers (1 bit each); wcnt and rcnt (3 bits each).
- Write
  - Accepted when in_valid && in_ready.
  - Writes bank[wbank][i][wcnt] = in_data[i] for all i, then wcnt++.
  - On wcnt==7 accept: full[wbank] set, wbank toggles, wcnt wraps to 0.
- Write ready
  - in_ready = !full[wbank].
- Read
  - out_valid = full[rbank].
  - out_data[c] = bank[rbank][rcnt][c] while out_valid; all zeros while out_valid=0.
  - out_last = out_valid && rcnt==7.
  - Transfer when out_valid && out_ready: rcnt++.
  - On rcnt==7 transfer: full[rbank] cleared, rbank toggles, rcnt wraps to 0.
- Latency
  - Row 0 of a block is presented (out_valid=1) in the cycle after the 8th column is accepted.
  - With out_ready held high, one row per cycle.
  - Sustained throughput: one vector per cycle in and out.
- Simultaneous events
  - Finishing a write on one bank and finishing a read on the other bank in the same cycle: both flags update, no conflict.
  - A bank freed by a read becomes writable the next cycle. No same-cycle bypass; in_ready depends only on registered state.
  - Both banks full: in_ready=0 and input stalls. No data is lost or overwritten.
- Backpressure
  - out_ready=0 holds out_data, out_last and rcnt stable.
  - in_valid while in_ready=0 has no write effect and sets overrun.
- clear
  - Highest synchronous priority.
  - Next cycle: full flags=0, pointers=0, counters=0, overrun=0.
  - Memory contents are not cleared.
  - Any write or read in the same cycle is discarded.
- Reset (rst_n=0, any time, including mid-block)
  - Immediately: full flags=0, wbank=rbank=0, wcnt=rcnt=0, overrun=0.
  - Outputs during reset: in_ready=1, out_valid=0, out_data=0, out_last=0.
  - Memory is not reset.
  - A partially written block is discarded.
- Arithmetic
  - None; values pass bit-exact, signed, no width change.

Test Plan:
- Single block: write columns k=0..7 with in_data[i]=8k+i, out_ready=1 -> out_valid rises the cycle after the 8th accept; row r has out_data[c]=8c+r; out_last only on row 7; in_ready stays 1 throughout.
- Back-to-back blocks: 24 consecutive columns with values 100·blk+8k+i, out_ready=1 -> three blocks emerge transposed and in order; in_ready never drops.
- Backpressure: out_ready=0 while writing 17 columns -> in_ready=0 after the 16th accept; the 17th is held and overrun stays 0. Drive in_valid=1 during the stall -> overrun=1. Release out_ready -> block 0 then block 1 rows correct.
- Signed extremes: column 0 all -512, column 7 all +511, others 0 -> every row has out_data[0]=-512 and out_data[7]=+511.
- Reset mid-block: assert rst_n=0 after 5 columns -> outputs go to reset values immediately. Next 8 columns (values 1..64) produce exactly one correct block, with no residue from the aborted block.
- clear during read of row 3 -> next cycle out_valid=0 and in_ready=1. A fresh 8-column write produces correct output starting at row 0.
